wb_regfile: RTL and testbench
=============================

WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1: asynchronous reset, active-high.
REQ-003 SHALL have port wb_wd, input, 5: GPR write address from the MEM/WB stage register.
REQ-004 SHALL have port wb_wreg, input, 1: GPR write enable.
REQ-005 SHALL have port wb_wdata, input, 32: GPR write data.
REQ-006 SHALL have ports wb_hi and wb_lo, input, 32 each: HI/LO write data.
REQ-007 SHALL have port wb_we, input, 1: HI/LO write enable.
REQ-008 SHALL have port wb_flags, input, 32: FLAGS write data.
REQ-009 SHALL have ports wb_llbit_we, input, 1, and wb_llbit_value, input, 1: LLbit write.
REQ-010 SHALL have port flush, input, 1: exception/pipeline flush.
REQ-011 SHALL have ports re1 and re2, input, 1 each, and raddr1 and raddr2, input, 5 each: decode-stage read requests.
REQ-012 SHALL have ports rdata1 and rdata2, output, 32 each: read data, combinational.
REQ-013 SHALL have ports hi_o, lo_o and flags_o, output, 32 each; llbit_o, output, 1: committed and bypassed special registers.
REQ-014 SHALL have port commit_cnt, output, 32: count of committed writes.

Function
REQ-015 SHALL hold 32x32 GPRs; on a clock edge with wb_wreg=1 and wb_wd!=0, write wb_wdata to GPR[wb_wd].
REQ-016 SHALL ignore writes to GPR0; reads of address 0 SHALL return 0.
REQ-017 rdataN SHALL be 0 when reN=0.
REQ-018 rdataN SHALL be wb_wdata in the same cycle when reN=1, raddrN=wb_wd, wb_wreg=1 and raddrN!=0 (write-through bypass, zero latency). Otherwise it SHALL be GPR[raddrN].
REQ-019 Both read ports SHALL be independent; identical addresses on both ports SHALL return identical data.
REQ-020 On a clock edge with wb_we=1, SHALL load HI<=wb_hi and LO<=wb_lo together.
REQ-021 hi_o/lo_o SHALL be wb_hi/wb_lo when wb_we=1, else the HI/LO registers (same-cycle bypass).
REQ-022 On a clock edge with wb_wreg=1 or wb_we=1, SHALL load FLAGS<=wb_flags.
REQ-023 flags_o SHALL be wb_flags when (wb_wreg or wb_we)=1, else the FLAGS register.
REQ-024 LLbit: flush=1 SHALL clear it to 0 at the edge, with priority over wb_llbit_we. Otherwise wb_llbit_we=1 SHALL load wb_llbit_value.
REQ-025 llbit_o SHALL be 0 when flush=1; else wb_llbit_value when wb_llbit_we=1; else the LLbit register.
REQ-026 flush SHALL NOT block GPR, HI/LO or FLAGS writes presented in the same cycle; the upstream stage register zeroes its enables on flush.
REQ-027 commit_cnt SHALL increment by 1 on each edge with (wb_wreg or wb_we)=1, including writes to GPR0.
REQ-028 commit_cnt SHALL wrap 0xFFFFFFFF to 0 and SHALL NOT be cleared by flush.
REQ-029 All write decisions SHALL use values sampled at the rising edge; a simultaneous GPR write and HI/LO write SHALL both take effect.

Reset
REQ-030 rst=1 SHALL immediately, without a clock, force all GPRs, HI, LO, FLAGS, LLbit and commit_cnt to 0.
REQ-031 While rst=1, all writes SHALL be blocked; bypass paths remain combinational on inputs.
REQ-032 Reset asserted mid-operation SHALL discard any write on that edge; the first write after deassertion SHALL occur on the first rising edge with rst=0.

Verification
REQ-033 Write GPR5=0x12345678, then read raddr1=5, re1=1 next cycle -> rdata1=0x12345678; same cycle with wb_wd=5 -> bypassed 0x12345678.
REQ-034 Write GPR0=0xFFFFFFFF with wb_wreg=1 -> rdata1(addr 0)=0; commit_cnt increments by 1.
REQ-035 wb_we=1, wb_hi=0xAAAA0000, wb_lo=0x0000BBBB -> hi_o/lo_o show values same cycle and hold them after wb_we=0.
REQ-036 wb_llbit_we=1, value=1, flush=1 same cycle -> llbit_o=0 and LLbit=0 after edge; next write of 1 without flush -> llbit_o=1.
REQ-037 Preload commit_cnt to 0xFFFFFFFE via writes/force, then two commit cycles -> 0xFFFFFFFF, then 0x00000000.
REQ-038 Assert rst between edges after writing GPR7=0x5 -> rdata1(addr 7)=0 and commit_cnt=0 before the next edge.

Source files
------------

// File: rtl/wb_regfile.sv
// Write-back stage register file: 32x32 GPRs, HI/LO, FLAGS, LLbit and a commit counter,
// with zero-latency write-through bypass on every read path.
module wb_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  wb_wd,
    input  logic        wb_wreg,
    input  logic [31:0] wb_wdata,
    input  logic [31:0] wb_hi,
    input  logic [31:0] wb_lo,
    input  logic        wb_we,
    input  logic [31:0] wb_flags,
    input  logic        wb_llbit_we,
    input  logic        wb_llbit_value,
    input  logic        flush,
    input  logic        re1,
    input  logic [4:0]  raddr1,
    input  logic        re2,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic [31:0] flags_o,
    output logic        llbit_o,
    output logic [31:0] commit_cnt
);

    logic [31:0] gpr_q [32];
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] flags_q, flags_d;
    logic        llbit_q, llbit_d;
    logic [31:0] commit_cnt_q, commit_cnt_d;
    logic        commit;

    assign commit = wb_wreg | wb_we;

    // GPR0 is hardwired to zero, so only the bypass and the array need the address-zero guard
    function automatic logic [31:0] readPort(input logic re, input logic [4:0] addr);
        logic [31:0] value;
        value = '0;
        if (re && addr != 5'd0) begin
            if (wb_wreg && addr == wb_wd) begin
                value = wb_wdata;
            end else begin
                value = gpr_q[addr];
            end
        end
        return value;
    endfunction

    assign rdata1 = readPort(re1, raddr1);
    assign rdata2 = readPort(re2, raddr2);

    always_comb begin
        hi_d         = hi_q;
        lo_d         = lo_q;
        flags_d      = flags_q;
        llbit_d      = llbit_q;
        commit_cnt_d = commit_cnt_q;
        if (wb_we) begin
            hi_d = wb_hi;
            lo_d = wb_lo;
        end
        if (commit) begin
            flags_d      = wb_flags;
            commit_cnt_d = commit_cnt_q + 32'd1;
        end
        // A flush kills a pending LL reservation even if the same instruction sets it
        if (flush) begin
            llbit_d = 1'b0;
        end else if (wb_llbit_we) begin
            llbit_d = wb_llbit_value;
        end
    end

    assign hi_o       = hi_d;
    assign lo_o       = lo_d;
    assign flags_o    = flags_d;
    assign llbit_o    = llbit_d;
    assign commit_cnt = commit_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                gpr_q[i] <= '0;
            end
        end else if (wb_wreg && wb_wd != 5'd0) begin
            gpr_q[wb_wd] <= wb_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q         <= '0;
            lo_q         <= '0;
            flags_q      <= '0;
            llbit_q      <= 1'b0;
            commit_cnt_q <= '0;
        end else begin
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            flags_q      <= flags_d;
            llbit_q      <= llbit_d;
            commit_cnt_q <= commit_cnt_d;
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed scoreboard bench for wb_regfile: expectations are queued as each step is driven
// and drained against the DUT outputs once they have settled.
module tb_wb_regfile;

    logic        clk;
    logic        rst;
    logic [4:0]  wb_wd;
    logic        wb_wreg;
    logic [31:0] wb_wdata;
    logic [31:0] wb_hi;
    logic [31:0] wb_lo;
    logic        wb_we;
    logic [31:0] wb_flags;
    logic        wb_llbit_we;
    logic        wb_llbit_value;
    logic        flush;
    logic        re1;
    logic [4:0]  raddr1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic [31:0] flags_o;
    logic        llbit_o;
    logic [31:0] commit_cnt;

    typedef struct {
        string       sig;
        string       name;
        logic [31:0] exp;
    } expect_t;

    expect_t     sbq[$];
    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] modelCnt    = 32'd0;

    wb_regfile dut (
        .clk            (clk),
        .rst            (rst),
        .wb_wd          (wb_wd),
        .wb_wreg        (wb_wreg),
        .wb_wdata       (wb_wdata),
        .wb_hi          (wb_hi),
        .wb_lo          (wb_lo),
        .wb_we          (wb_we),
        .wb_flags       (wb_flags),
        .wb_llbit_we    (wb_llbit_we),
        .wb_llbit_value (wb_llbit_value),
        .flush          (flush),
        .re1            (re1),
        .raddr1         (raddr1),
        .re2            (re2),
        .raddr2         (raddr2),
        .rdata1         (rdata1),
        .rdata2         (rdata2),
        .hi_o           (hi_o),
        .lo_o           (lo_o),
        .flags_o        (flags_o),
        .llbit_o        (llbit_o),
        .commit_cnt     (commit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic pushExpect(input string sig, input string name, input logic [31:0] exp);
        expect_t e;
        e.sig  = sig;
        e.name = name;
        e.exp  = exp;
        sbq.push_back(e);
    endtask

    function automatic logic [31:0] observe(input string sig);
        logic [31:0] v;
        v = 32'hDEADBEEF;
        case (sig)
            "rdata1": v = rdata1;
            "rdata2": v = rdata2;
            "hi":     v = hi_o;
            "lo":     v = lo_o;
            "flags":  v = flags_o;
            "llbit":  v = {31'd0, llbit_o};
            "cnt":    v = commit_cnt;
            default:  v = 32'hDEADBEEF;
        endcase
        return v;
    endfunction

    task automatic checkOutput();
        expect_t     e;
        logic [31:0] obs;
        #1;
        while (sbq.size() > 0) begin
            e   = sbq.pop_front();
            obs = observe(e.sig);
            vectors++;
            assert (obs === e.exp) else begin
                miscompares++;
                $error("[TB] FAIL %s: observed %h expected %h", e.name, obs, e.exp);
            end
        end
    endtask

    task automatic idleInputs();
        wb_wd          = 5'd0;
        wb_wreg        = 1'b0;
        wb_wdata       = 32'd0;
        wb_hi          = 32'd0;
        wb_lo          = 32'd0;
        wb_we          = 1'b0;
        wb_flags       = 32'd0;
        wb_llbit_we    = 1'b0;
        wb_llbit_value = 1'b0;
        flush          = 1'b0;
        re1            = 1'b0;
        raddr1         = 5'd0;
        re2            = 1'b0;
        raddr2         = 5'd0;
    endtask

    // Advance one edge, update the commit model from what was presented, then go idle
    task automatic applyStimulus();
        if (!rst && (wb_wreg || wb_we)) modelCnt = modelCnt + 32'd1;
        @(posedge clk);
        #1;
        idleInputs();
    endtask

    initial begin
        rst = 1'b1;
        idleInputs();
        re1 = 1'b1; raddr1 = 5'd5;
        pushExpect("rdata1", "reset_gpr5", 32'd0);
        pushExpect("hi", "reset_hi", 32'd0);
        pushExpect("lo", "reset_lo", 32'd0);
        pushExpect("flags", "reset_flags", 32'd0);
        pushExpect("llbit", "reset_llbit", 32'd0);
        pushExpect("cnt", "reset_cnt", 32'd0);
        checkOutput();
        @(negedge clk);
        rst = 1'b0;

        // GPR write with same-cycle bypass on both ports
        @(negedge clk);
        wb_wreg = 1'b1; wb_wd = 5'd5; wb_wdata = 32'h12345678; wb_flags = 32'h11;
        re1 = 1'b1; raddr1 = 5'd5; re2 = 1'b1; raddr2 = 5'd5;
        pushExpect("rdata1", "bypass_p1", 32'h12345678);
        pushExpect("rdata2", "bypass_p2", 32'h12345678);
        pushExpect("flags", "flags_bypass", 32'h11);
        checkOutput();
        applyStimulus();
        re1 = 1'b1; raddr1 = 5'd5;
        pushExpect("rdata1", "gpr5_read", 32'h12345678);
        pushExpect("flags", "flags_held", 32'h11);
        pushExpect("cnt", "cnt_after_w5", modelCnt);
        checkOutput();

        // Disabled port, and no bypass while wb_wreg is low
        @(negedge clk);
        wb_wd = 5'd5; wb_wdata = 32'h0000DEAD;
        re1 = 1'b0; raddr1 = 5'd5; re2 = 1'b1; raddr2 = 5'd5;
        pushExpect("rdata1", "re1_off", 32'd0);
        pushExpect("rdata2", "no_bypass_wreg0", 32'h12345678);
        checkOutput();
        applyStimulus();

        // GPR0 write: discarded but still counted
        @(negedge clk);
        wb_wreg = 1'b1; wb_wd = 5'd0; wb_wdata = 32'hFFFFFFFF;
        re1 = 1'b1; raddr1 = 5'd0;
        pushExpect("rdata1", "gpr0_bypass_zero", 32'd0);
        checkOutput();
        applyStimulus();
        re1 = 1'b1; raddr1 = 5'd0;
        pushExpect("rdata1", "gpr0_read_zero", 32'd0);
        pushExpect("cnt", "cnt_after_gpr0", modelCnt);
        checkOutput();

        // HI/LO bypass and hold
        @(negedge clk);
        wb_we = 1'b1; wb_hi = 32'hAAAA0000; wb_lo = 32'h0000BBBB; wb_flags = 32'h22;
        pushExpect("hi", "hi_bypass", 32'hAAAA0000);
        pushExpect("lo", "lo_bypass", 32'h0000BBBB);
        pushExpect("flags", "flags_we_bypass", 32'h22);
        checkOutput();
        applyStimulus();
        pushExpect("hi", "hi_held", 32'hAAAA0000);
        pushExpect("lo", "lo_held", 32'h0000BBBB);
        pushExpect("flags", "flags_we_held", 32'h22);
        pushExpect("cnt", "cnt_after_hilo", modelCnt);
        checkOutput();

        // Simultaneous GPR and HI/LO write counts once
        @(negedge clk);
        wb_wreg = 1'b1; wb_wd = 5'd9; wb_wdata = 32'hCAFEF00D;
        wb_we = 1'b1; wb_hi = 32'h1; wb_lo = 32'h2; wb_flags = 32'h33;
        applyStimulus();
        re1 = 1'b1; raddr1 = 5'd9; re2 = 1'b1; raddr2 = 5'd5;
        pushExpect("rdata1", "dual_gpr9", 32'hCAFEF00D);
        pushExpect("rdata2", "port2_indep_gpr5", 32'h12345678);
        pushExpect("hi", "dual_hi", 32'h1);
        pushExpect("lo", "dual_lo", 32'h2);
        pushExpect("cnt", "cnt_after_dual", modelCnt);
        checkOutput();

        // Flush does not block GPR writes
        @(negedge clk);
        flush = 1'b1; wb_wreg = 1'b1; wb_wd = 5'd10; wb_wdata = 32'hA5;
        applyStimulus();
        re1 = 1'b1; raddr1 = 5'd10;
        pushExpect("rdata1", "flush_gpr10", 32'hA5);
        pushExpect("cnt", "cnt_after_flush", modelCnt);
        checkOutput();

        // LLbit: flush has priority, then normal set, bypass and clear
        @(negedge clk);
        wb_llbit_we = 1'b1; wb_llbit_value = 1'b1; flush = 1'b1;
        pushExpect("llbit", "llbit_flush_comb", 32'd0);
        checkOutput();
        applyStimulus();
        pushExpect("llbit", "llbit_flush_reg", 32'd0);
        checkOutput();
        @(negedge clk);
        wb_llbit_we = 1'b1; wb_llbit_value = 1'b1;
        pushExpect("llbit", "llbit_set_comb", 32'd1);
        checkOutput();
        applyStimulus();
        pushExpect("llbit", "llbit_set_reg", 32'd1);
        checkOutput();
        @(negedge clk);
        wb_llbit_we = 1'b1; wb_llbit_value = 1'b0;
        pushExpect("llbit", "llbit_clr_bypass", 32'd0);
        checkOutput();
        wb_llbit_we = 1'b0; flush = 1'b1;
        pushExpect("llbit", "llbit_flush_only", 32'd0);
        checkOutput();
        applyStimulus();
        pushExpect("llbit", "llbit_after_flush", 32'd0);
        checkOutput();

        // Counter wrap from a preloaded value
        @(negedge clk);
        force dut.commit_cnt_q = 32'hFFFFFFFE;
        #1;
        release dut.commit_cnt_q;
        modelCnt = 32'hFFFFFFFE;
        pushExpect("cnt", "cnt_preload", modelCnt);
        checkOutput();
        @(negedge clk);
        wb_wreg = 1'b1; wb_wd = 5'd0;
        applyStimulus();
        pushExpect("cnt", "cnt_max", 32'hFFFFFFFF);
        checkOutput();
        @(negedge clk);
        wb_we = 1'b1;
        applyStimulus();
        pushExpect("cnt", "cnt_wrap", 32'h00000000);
        pushExpect("cnt", "cnt_wrap_model", modelCnt);
        checkOutput();

        // Async reset between edges, writes blocked while held, first write after release
        @(negedge clk);
        wb_wreg = 1'b1; wb_wd = 5'd7; wb_wdata = 32'h5;
        applyStimulus();
        @(negedge clk);
        #2;
        rst = 1'b1;
        re1 = 1'b1; raddr1 = 5'd7;
        pushExpect("rdata1", "rst_gpr7", 32'd0);
        pushExpect("cnt", "rst_cnt", 32'd0);
        pushExpect("hi", "rst_hi", 32'd0);
        checkOutput();
        modelCnt = 32'd0;
        wb_wreg = 1'b1; wb_wd = 5'd8; wb_wdata = 32'h77; re1 = 1'b1; raddr1 = 5'd8;
        pushExpect("rdata1", "rst_bypass_live", 32'h77);
        checkOutput();
        applyStimulus();
        @(negedge clk);
        rst = 1'b0;
        re1 = 1'b1; raddr1 = 5'd8;
        pushExpect("rdata1", "rst_blocked_gpr8", 32'd0);
        pushExpect("cnt", "rst_blocked_cnt", 32'd0);
        checkOutput();
        wb_wreg = 1'b1; wb_wd = 5'd8; wb_wdata = 32'h77;
        applyStimulus();
        re1 = 1'b1; raddr1 = 5'd8;
        pushExpect("rdata1", "post_rst_gpr8", 32'h77);
        pushExpect("cnt", "post_rst_cnt", modelCnt);
        checkOutput();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
